rvc_fetch_aligner: RTL and testbench

//  Sequences 32-bit fetch packets into single instructions for the RVC expander.

---
 rtl/rvc_fetch_pkg.sv | 23 ++
 rtl/rvc_fetch_aligner_if.sv | 33 +++
 rtl/rvc_fetch_aligner.sv | 185 ++++++++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rvc_fetch_pkg.sv
// Shared types and parcel helpers for the RVC fetch aligner.
package rvc_fetch_pkg;

    localparam int PARCEL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PKT0  = 2'd1,
        ST_PKT1  = 2'd2,
        ST_SPLIT = 2'd3
    } aligner_state_e;

    // A parcel starts a 16-bit instruction unless its two low bits are both set.
    function automatic logic is_rvc(input logic [PARCEL_W-1:0] parcel);
        return (parcel[1:0] != 2'b11);
    endfunction

    // 16-bit instructions travel to the expander zero-extended to 32 bits.
    function automatic logic [31:0] zext_rvc(input logic [PARCEL_W-1:0] parcel);
        return {16'h0000, parcel};
    endfunction

endpackage

// File: rtl/rvc_fetch_aligner_if.sv
// Fetch-packet and instruction handshake bundle between fetch queue, aligner and expander.
interface rvc_fetch_aligner_if #(
    parameter int XLEN = 32
);
    logic            io_fetch_valid;
    logic            io_fetch_ready;
    logic [31:0]     io_fetch_data;
    logic [XLEN-1:0] io_fetch_pc;
    logic            io_fetch_xcpt;
    logic            io_redirect;
    logic            io_inst_valid;
    logic            io_inst_ready;
    logic [31:0]     io_inst_raw;
    logic [XLEN-1:0] io_inst_pc;
    logic            io_inst_rvc;
    logic            io_inst_xcpt;

    // Environment side: supplies packets and redirects, consumes instructions.
    modport master (
        output io_fetch_valid, io_fetch_data, io_fetch_pc, io_fetch_xcpt,
               io_redirect, io_inst_ready,
        input  io_fetch_ready, io_inst_valid, io_inst_raw, io_inst_pc,
               io_inst_rvc, io_inst_xcpt
    );

    // Aligner side.
    modport slave (
        input  io_fetch_valid, io_fetch_data, io_fetch_pc, io_fetch_xcpt,
               io_redirect, io_inst_ready,
        output io_fetch_ready, io_inst_valid, io_inst_raw, io_inst_pc,
               io_inst_rvc, io_inst_xcpt
    );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// Splits 32-bit fetch packets into 16/32-bit instructions, stitching 32-bit
// instructions that straddle two packets, one instruction per cycle.
module rvc_fetch_aligner
    import rvc_fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit USE_RVC = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    rvc_fetch_aligner_if.slave io
);

    localparam logic [XLEN-1:0] PC_HI_PARCEL = {{(XLEN-2){1'b0}}, 2'b10};

    aligner_state_e    state_q, state_d;
    logic [31:0]       pkt_data_q, pkt_data_d;
    logic [XLEN-1:0]   pkt_pc_q, pkt_pc_d;
    logic              pkt_xcpt_q, pkt_xcpt_d;
    logic [PARCEL_W-1:0] lo_parcel_q, lo_parcel_d;
    logic [XLEN-1:0]   lo_pc_q, lo_pc_d;

    logic              load_s;
    logic              p0_rvc_s, p1_rvc_s;
    aligner_state_e    start_state_s;
    logic              fetch_ready_s, inst_valid_s, inst_rvc_s, inst_xcpt_s;
    logic [31:0]       inst_raw_s;
    logic [XLEN-1:0]   inst_pc_s;

    assign p0_rvc_s      = USE_RVC && is_rvc(pkt_data_q[15:0]);
    assign p1_rvc_s      = USE_RVC && is_rvc(pkt_data_q[31:16]);
    // A redirect target with pc[1] set starts at the upper parcel.
    assign start_state_s = (USE_RVC && io.io_fetch_pc[1]) ? ST_PKT1 : ST_PKT0;

    // Next-state, packet capture and instruction output selection.
    always_comb begin
        state_d       = state_q;
        pkt_data_d    = pkt_data_q;
        pkt_pc_d      = pkt_pc_q;
        pkt_xcpt_d    = pkt_xcpt_q;
        lo_parcel_d   = lo_parcel_q;
        lo_pc_d       = lo_pc_q;
        load_s        = 1'b0;
        fetch_ready_s = 1'b0;
        inst_valid_s  = 1'b0;
        inst_raw_s    = 32'h0000_0000;
        inst_pc_s     = {XLEN{1'b0}};
        inst_rvc_s    = 1'b0;
        inst_xcpt_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                fetch_ready_s = 1'b1;
                if (io.io_fetch_valid) begin
                    load_s  = 1'b1;
                    state_d = start_state_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT0: begin
                inst_valid_s = 1'b1;
                inst_pc_s    = pkt_pc_q;
                inst_xcpt_s  = pkt_xcpt_q;
                if (p0_rvc_s) begin
                    inst_raw_s = zext_rvc(pkt_data_q[15:0]);
                    inst_rvc_s = 1'b1;
                    if (io.io_inst_ready) begin
                        state_d = pkt_xcpt_q ? ST_IDLE : ST_PKT1;
                    end else begin
                        state_d = ST_PKT0;
                    end
                end else begin
                    inst_raw_s = pkt_data_q;
                    // A faulting packet ends here; otherwise overlap the next fetch.
                    fetch_ready_s = io.io_inst_ready && !pkt_xcpt_q;
                    if (io.io_inst_ready) begin
                        if (io.io_fetch_valid && !pkt_xcpt_q) begin
                            load_s  = 1'b1;
                            state_d = start_state_s;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PKT0;
                    end
                end
            end
            ST_PKT1: begin
                inst_pc_s   = pkt_pc_q | PC_HI_PARCEL;
                inst_xcpt_s = pkt_xcpt_q;
                if (p1_rvc_s || pkt_xcpt_q) begin
                    inst_valid_s  = 1'b1;
                    inst_raw_s    = zext_rvc(pkt_data_q[31:16]);
                    inst_rvc_s    = p1_rvc_s;
                    fetch_ready_s = io.io_inst_ready && !pkt_xcpt_q;
                    if (io.io_inst_ready) begin
                        if (io.io_fetch_valid && !pkt_xcpt_q) begin
                            load_s  = 1'b1;
                            state_d = start_state_s;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PKT1;
                    end
                end else begin
                    // Upper half of a straddling instruction: park it, one bubble.
                    inst_pc_s   = {XLEN{1'b0}};
                    inst_xcpt_s = 1'b0;
                    lo_parcel_d = pkt_data_q[31:16];
                    lo_pc_d     = pkt_pc_q | PC_HI_PARCEL;
                    state_d     = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                inst_valid_s  = io.io_fetch_valid;
                inst_raw_s    = {io.io_fetch_data[15:0], lo_parcel_q};
                inst_pc_s     = lo_pc_q;
                inst_xcpt_s   = io.io_fetch_xcpt;
                fetch_ready_s = io.io_inst_ready;
                if (io.io_fetch_valid && io.io_inst_ready) begin
                    load_s  = 1'b1;
                    state_d = io.io_fetch_xcpt ? ST_IDLE : ST_PKT1;
                end else begin
                    state_d = ST_SPLIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (io.io_redirect) begin
            // Flush wins over every pending handshake this cycle.
            load_s        = 1'b0;
            state_d       = ST_IDLE;
            lo_parcel_d   = lo_parcel_q;
            lo_pc_d       = lo_pc_q;
            fetch_ready_s = 1'b0;
            inst_valid_s  = 1'b0;
            inst_raw_s    = 32'h0000_0000;
            inst_pc_s     = {XLEN{1'b0}};
            inst_rvc_s    = 1'b0;
            inst_xcpt_s   = 1'b0;
        end else begin
            load_s = load_s;
        end

        if (load_s) begin
            pkt_data_d = io.io_fetch_data;
            pkt_pc_d   = io.io_fetch_pc;
            pkt_xcpt_d = io.io_fetch_xcpt;
        end else begin
            pkt_data_d = pkt_data_d;
        end
    end

    // State and packet buffer registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pkt_data_q  <= 32'h0000_0000;
            pkt_pc_q    <= {XLEN{1'b0}};
            pkt_xcpt_q  <= 1'b0;
            lo_parcel_q <= 16'h0000;
            lo_pc_q     <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            pkt_data_q  <= pkt_data_d;
            pkt_pc_q    <= pkt_pc_d;
            pkt_xcpt_q  <= pkt_xcpt_d;
            lo_parcel_q <= lo_parcel_d;
            lo_pc_q     <= lo_pc_d;
        end
    end

    assign io.io_fetch_ready = fetch_ready_s;
    assign io.io_inst_valid  = inst_valid_s;
    assign io.io_inst_raw    = inst_raw_s;
    assign io.io_inst_pc     = inst_pc_s;
    assign io.io_inst_rvc    = inst_rvc_s;
    assign io.io_inst_xcpt   = inst_xcpt_s;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed, table-driven bench for rvc_fetch_aligner.
module tb_rvc_fetch_aligner;

    logic clock;
    logic reset_n;

    rvc_fetch_aligner_if #(.XLEN(32)) bus ();

    rvc_fetch_aligner #(.XLEN(32), .USE_RVC(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        fv;
        logic [31:0] fd;
        logic [31:0] fpc;
        logic        fx;
        logic        redir;
        logic        ir;
        logic        ev;
        logic [31:0] eraw;
        logic [31:0] epc;
        logic        erv;
        logic        ex;
        logic        efr;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string nm, input logic fv, input logic [31:0] fd,
                       input logic [31:0] fpc, input logic fx, input logic redir,
                       input logic ir, input logic ev, input logic [31:0] eraw,
                       input logic [31:0] epc, input logic erv, input logic ex,
                       input logic efr);
        vec_t v;
        v.name = nm; v.fv = fv; v.fd = fd; v.fpc = fpc; v.fx = fx; v.redir = redir;
        v.ir = ir; v.ev = ev; v.eraw = eraw; v.epc = epc; v.erv = erv; v.ex = ex;
        v.efr = efr;
        vq.push_back(v);
    endtask

    task automatic drive(input logic fv, input logic [31:0] fd, input logic [31:0] fpc,
                         input logic fx, input logic redir, input logic ir);
        bus.io_fetch_valid = fv;
        bus.io_fetch_data  = fd;
        bus.io_fetch_pc    = fpc;
        bus.io_fetch_xcpt  = fx;
        bus.io_redirect    = redir;
        bus.io_inst_ready  = ir;
    endtask

    task automatic chk(input string nm, input logic ev, input logic [31:0] eraw,
                       input logic [31:0] epc, input logic erv, input logic ex,
                       input logic efr);
        logic [67:0] act;
        logic [67:0] exp;
        act = {bus.io_inst_valid, bus.io_inst_raw, bus.io_inst_pc, bus.io_inst_rvc,
               bus.io_inst_xcpt, bus.io_fetch_ready};
        exp = {ev, eraw, epc, erv, ex, efr};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual v=%b raw=%h pc=%h rvc=%b x=%b frdy=%b required v=%b raw=%h pc=%h rvc=%b x=%b frdy=%b",
                     nm, act[67], act[66:35], act[34:3], act[2], act[1], act[0],
                     ev, eraw, epc, erv, ex, efr);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_state", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        //   name           fv    data          pc            fx    rd    ir    ev    raw           ipc           rvc   x     frdy
        add("t1_idle",     1'b1, 32'h00010001, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t1_p0",       1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000100, 1'b1, 1'b0, 1'b0);
        add("t1_p1",       1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000102, 1'b1, 1'b0, 1'b1);
        add("t2_idle",     1'b1, 32'h00B30001, 32'h00000200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t2_p0",       1'b1, 32'h12340293, 32'h00000204, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000200, 1'b1, 1'b0, 1'b0);
        add("t2_bubble",   1'b1, 32'h12340293, 32'h00000204, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        add("t2_split",    1'b1, 32'h12340293, 32'h00000204, 1'b0, 1'b0, 1'b1, 1'b1, 32'h029300B3, 32'h00000202, 1'b0, 1'b0, 1'b1);
        add("t2_p1",       1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00001234, 32'h00000206, 1'b1, 1'b0, 1'b1);
        add("t3_idle",     1'b1, 32'h00A00513, 32'h00000300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t3_stall0",   1'b1, 32'h00010001, 32'h00000304, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00513, 32'h00000300, 1'b0, 1'b0, 1'b0);
        add("t3_stall1",   1'b1, 32'h00010001, 32'h00000304, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00513, 32'h00000300, 1'b0, 1'b0, 1'b0);
        add("t3_stall2",   1'b1, 32'h00010001, 32'h00000304, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00A00513, 32'h00000300, 1'b0, 1'b0, 1'b0);
        add("t3_b2b",      1'b1, 32'h00010001, 32'h00000304, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00A00513, 32'h00000300, 1'b0, 1'b0, 1'b1);
        add("t3_p0",       1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000304, 1'b1, 1'b0, 1'b0);
        add("t3_p1",       1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000306, 1'b1, 1'b0, 1'b1);
        add("t4_idle",     1'b1, 32'h00B30001, 32'h00000400, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t4_p0",       1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000400, 1'b1, 1'b0, 1'b0);
        add("t4_bubble",   1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        add("t4_redirect", 1'b1, 32'h12340293, 32'h00000404, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        add("t4_idle2",    1'b1, 32'h45640001, 32'h00000302, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t4_target",   1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00004564, 32'h00000302, 1'b1, 1'b0, 1'b1);
        add("t5_idle",     1'b1, 32'h00130013, 32'h00000500, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t5_fault",    1'b1, 32'h00010001, 32'h00000504, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00130013, 32'h00000500, 1'b0, 1'b1, 1'b0);
        add("t5_dropped",  1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t5b_idle",    1'b1, 32'h00010001, 32'h00000600, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        add("t5b_fault",   1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 32'h00000600, 1'b1, 1'b1, 1'b0);
        add("t5b_dropped", 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);

        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            drive(vq[i].fv, vq[i].fd, vq[i].fpc, vq[i].fx, vq[i].redir, vq[i].ir);
            #1;
            chk(vq[i].name, vq[i].ev, vq[i].eraw, vq[i].epc, vq[i].erv, vq[i].ex, vq[i].efr);
        end

        // Asynchronous reset while holding a stalled instruction in PKT1.
        @(negedge clock);
        drive(1'b1, 32'h00010001, 32'h00000702, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t6_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t6_pkt1", 1'b1, 32'h00000001, 32'h00000702, 1'b1, 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t6_after_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        #1;
        chk("t6_still_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
